// File: rtl/clink_pkg.sv
// Shared types and constants for the Clink_MVM timestep scheduler.
package clink_pkg;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    // Cycles from kernel enable to a valid region select.
    localparam int unsigned MVM_LAT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] gate;
        logic [2:0] neuron;
    } tag_t;

endpackage

// File: rtl/clink_tag_pipe.sv
// Fixed-depth shift register of result tags; reports whether any tag is still in flight.
module clink_tag_pipe
    import clink_pkg::*;
#(
    parameter int unsigned DEPTH = 5
) (
    input  logic clock,
    input  logic reset_n,
    input  tag_t tag_in,
    output tag_t tail,
    output logic pre_valid,
    output logic any_valid
);

    tag_t [DEPTH-1:0] stage_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[DEPTH-2:0], tag_in};
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign tail      = stage_q[DEPTH-1];
    assign pre_valid = stage_q[DEPTH-2].valid;

endmodule

// File: rtl/clink_mvm_sched.sv
// Issues 4 x N_NEURON kernel rows per timestep and realigns tagged kernel results.
// Define CLINK_MVM_HOLD_EN to add a hold input that stalls row issue.
module clink_mvm_sched
    import clink_pkg::*;
#(
    parameter int unsigned N_NEURON  = 5,
    parameter int unsigned WT_AW     = 7,
    parameter int unsigned WT_BASE   = 0,
    parameter int unsigned TANH_GATE = 2,
    parameter int unsigned MVM_LAT   = clink_pkg::MVM_LAT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
`ifdef CLINK_MVM_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             done,
    output logic             wt_rd_en,
    output logic [WT_AW-1:0] wt_addr,
    output logic             mvm_enable,
    output logic             mvm_istanh,
    input  logic [9:0]       mvm_output,
    input  logic [1:0]       mvm_sel,
    output logic             res_valid,
    output logic [1:0]       res_gate,
    output logic [2:0]       res_neuron,
    output logic [9:0]       res_mag,
    output logic [1:0]       res_sel
);

    state_t     state_q, state_d;
    logic [1:0] gate_q, gate_d;
    logic [2:0] neuron_q, neuron_d;
    logic       hold_w;
    logic       last_op;
    logic       row_end;
    tag_t       tag_in;
    tag_t       tail;
    logic       pre_valid;
    logic       any_valid;
    logic [9:0] mag_q;

`ifdef CLINK_MVM_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign row_end = (32'(neuron_q) == N_NEURON - 1);
    assign last_op = (gate_q == GATE_O) && row_end;

    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        neuron_d = neuron_q;
        wt_rd_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StIssue;
                    gate_d   = '0;
                    neuron_d = '0;
                end
            end
            StIssue: begin
                if (!hold_w) begin
                    wt_rd_en = 1'b1;
                    // The counter parks on the last op so wt_addr holds after the timestep.
                    if (last_op) begin
                        state_d = StDrain;
                    end else if (row_end) begin
                        neuron_d = '0;
                        gate_d   = gate_q + 2'd1;
                    end else begin
                        neuron_d = neuron_q + 3'd1;
                    end
                end
            end
            StDrain: begin
                if (!any_valid) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            gate_q   <= '0;
            neuron_q <= '0;
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            neuron_q <= neuron_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign wt_addr = WT_AW'(WT_BASE + 32'(gate_q) * N_NEURON + 32'(neuron_q));

    assign tag_in.valid  = wt_rd_en;
    assign tag_in.gate   = gate_q;
    assign tag_in.neuron = neuron_q;

    clink_tag_pipe #(
        .DEPTH (MVM_LAT + 1)
    ) u_tag_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .tag_in    (tag_in),
        .tail      (tail),
        .pre_valid (pre_valid),
        .any_valid (any_valid)
    );

    // Magnitude arrives one cycle ahead of the region select; hold it to line them up.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mvm_enable <= 1'b0;
            mvm_istanh <= 1'b0;
            mag_q      <= '0;
            res_valid  <= 1'b0;
            res_gate   <= '0;
            res_neuron <= '0;
            res_mag    <= '0;
            res_sel    <= '0;
        end else begin
            mvm_enable <= wt_rd_en;
            if (wt_rd_en) begin
                mvm_istanh <= (32'(gate_q) == TANH_GATE);
            end
            if (pre_valid) begin
                mag_q <= mvm_output;
            end
            res_valid <= tail.valid;
            if (tail.valid) begin
                res_gate   <= tail.gate;
                res_neuron <= tail.neuron;
                res_mag    <= mag_q;
                res_sel    <= mvm_sel;
            end
        end
    end

endmodule

// File: tb/tb_clink_mvm_sched.sv
// Randomized bench for clink_mvm_sched against a per-cycle schedule model.
module tb_clink_mvm_sched;

    localparam int N    = 5;
    localparam int NOPS = 4 * N;
    localparam int MAXC = 1024;
    localparam int RUNC = 980;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
`ifdef CLINK_MVM_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic [9:0] mvm_output = '0;
    logic [1:0] mvm_sel = '0;
    logic       busy, done, wt_rd_en, mvm_enable, mvm_istanh, res_valid;
    logic [6:0] wt_addr;
    logic [1:0] res_gate, res_sel;
    logic [2:0] res_neuron;
    logic [9:0] res_mag;

    always #5 clock = ~clock;

    clink_mvm_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
`ifdef CLINK_MVM_HOLD_EN
        .hold       (hold),
`endif
        .busy       (busy),
        .done       (done),
        .wt_rd_en   (wt_rd_en),
        .wt_addr    (wt_addr),
        .mvm_enable (mvm_enable),
        .mvm_istanh (mvm_istanh),
        .mvm_output (mvm_output),
        .mvm_sel    (mvm_sel),
        .res_valid  (res_valid),
        .res_gate   (res_gate),
        .res_neuron (res_neuron),
        .res_mag    (res_mag),
        .res_sel    (res_sel)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int idle_from = 0;

    // Expected op per cycle (-1 = none) and level signals per cycle.
    int exp_rd   [MAXC];
    int exp_en   [MAXC];
    int exp_res  [MAXC];
    int exp_addr [MAXC];
    bit exp_done [MAXC];
    bit exp_busy [MAXC];
    bit start_a  [MAXC];
    bit hold_a   [MAXC];
    bit rst_lo   [MAXC];
    // Kernel environment: what the DUT actually read/enabled.
    int rd_obs   [MAXC];
    int en_op    [MAXC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_rd[i]   = -1;
            exp_en[i]   = -1;
            exp_res[i]  = -1;
            exp_addr[i] = 0;
            exp_done[i] = 1'b0;
            exp_busy[i] = 1'b0;
        end
    endtask

    // A timestep accepted in cycle s: one op per non-held cycle from s+1,
    // enable one cycle later, result six cycles later, done after the last result.
    task automatic schedule(input int s);
        int op = 0;
        int t = s + 1;
        int dc;
        while (op < NOPS && t < MAXC - 8) begin
            exp_busy[t] = 1'b1;
            exp_addr[t] = op;
            if (!hold_a[t]) begin
                exp_rd[t]      = op;
                exp_en[t + 1]  = op;
                exp_res[t + 6] = op;
                op++;
            end
            t++;
        end
        dc = t + 6;
        for (int u = t; u < MAXC; u++) begin
            exp_addr[u] = NOPS - 1;
            if (u <= dc) exp_busy[u] = 1'b1;
        end
        if (dc < MAXC) exp_done[dc] = 1'b1;
        idle_from = dc + 1;
    endtask

    task automatic step();
        int op;
        @(posedge clock);
        #1;
        reset_n = !rst_lo[cyc];
        if (rst_lo[cyc]) begin
            clear_from(cyc);
            idle_from = cyc + 1;
        end
        start = start_a[cyc];
`ifdef CLINK_MVM_HOLD_EN
        hold = hold_a[cyc];
`endif
        if (start && reset_n && cyc >= idle_from) schedule(cyc);
        mvm_output = (cyc >= 3 && en_op[cyc - 3] >= 0) ? 10'(en_op[cyc - 3] * 3) : 10'($urandom);
        mvm_sel    = (cyc >= 4 && en_op[cyc - 4] >= 0) ? 2'(en_op[cyc - 4] % 4) : 2'($urandom);
        #1;
        rd_obs[cyc] = wt_rd_en ? int'(wt_addr) : -1;
        en_op[cyc]  = (mvm_enable && cyc > 0) ? rd_obs[cyc - 1] : -1;

        check("busy", busy, exp_busy[cyc]);
        check("done", done, exp_done[cyc]);
        check("wt_rd_en", wt_rd_en, exp_rd[cyc] >= 0);
        check("wt_addr", wt_addr, exp_addr[cyc]);
        check("mvm_enable", mvm_enable, exp_en[cyc] >= 0);
        if (exp_en[cyc] >= 0) check("mvm_istanh", mvm_istanh, (exp_en[cyc] / N) == 2);
        check("res_valid", res_valid, exp_res[cyc] >= 0);
        if (exp_res[cyc] >= 0) begin
            op = exp_res[cyc];
            check("res_gate", res_gate, op / N);
            check("res_neuron", res_neuron, op % N);
            check("res_mag", res_mag, (op * 3) % 1024);
            check("res_sel", res_sel, op % 4);
        end
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            start_a[i] = 1'b0;
            hold_a[i]  = 1'b0;
            rst_lo[i]  = 1'b0;
            rd_obs[i]  = -1;
            en_op[i]   = -1;
        end
        clear_from(0);

        // Power-on reset, then a clean timestep with stray starts while busy and on done.
        for (int i = 0; i < 3; i++) rst_lo[i] = 1'b1;
        start_a[5]  = 1'b1;
        start_a[10] = 1'b1;
        start_a[32] = 1'b1;
        start_a[34] = 1'b1;
`ifdef CLINK_MVM_HOLD_EN
        for (int i = 39; i <= 42; i++) hold_a[i] = 1'b1;
`endif
        // Reset mid-timestep, followed by a quiet stretch.
        start_a[70] = 1'b1;
        rst_lo[80]  = 1'b1;
        rst_lo[81]  = 1'b1;
        // Random starts (and holds when present).
        for (int i = 120; i < 880; i++) begin
            start_a[i] = ($urandom_range(7) == 0);
`ifdef CLINK_MVM_HOLD_EN
            hold_a[i] = ($urandom_range(3) == 0);
`endif
        end

        while (cyc < RUNC) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
